ita_run_sequencer: RTL

Run controller for the expand/contract inference pipeline. On a start command it issues a configurable number of inference runs into the expand engine. For each run it waits for the contract engine result and captures the result vector. It then streams one framed packet per run to the UART transmitter and reports progress, completion and fault status to the board-level LEDs/switch logic.

---
 rtl/ita_run_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ita_run_sequencer.sv
// Run controller for the expand/contract inference pipeline: issues N runs,
// captures each result vector and streams one framed packet per run to a UART.
//
// Handshakes:
//   eng_in_valid / eng_in_ready : valid is raised on ISSUE entry and held
//     until a cycle where ready is also high; that cycle is the transfer.
//   tx_valid / tx_busy : tx_valid is a one-cycle strobe, only ever raised
//     while tx_busy is low (tx_busy acts as an inverted ready).
//   abort forces both valid outputs low in the cycle it is seen.
module ita_run_sequencer #(
  parameter int OUTPUT_DIM     = 64,
  parameter int ACT_BITS       = 8,
  parameter int RUN_CNT_BITS   = 8,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [RUN_CNT_BITS-1:0]      num_runs,
  input  logic                         abort,
  output logic                         eng_in_valid,
  input  logic                         eng_in_ready,
  input  logic                         eng_out_valid,
  input  logic [OUTPUT_DIM*ACT_BITS-1:0] eng_out_vec,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_busy,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   err,
  output logic [RUN_CNT_BITS-1:0]      run_idx,
  output logic [2:0]                   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_RES = 3'd2,
    S_TX_ISSUE = 3'd3,
    S_TX_WAIT  = 3'd4,
    S_NEXT     = 3'd5
  } state_t;

  localparam int FRAME_LEN = OUTPUT_DIM + 3;
  localparam int BIW       = $clog2(FRAME_LEN);
  localparam int TCW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(FRAME_LEN - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ABORT   = 2'd2;

  state_t                        state_q, state_d;
  logic [RUN_CNT_BITS-1:0]       runs_q;
  logic [BIW-1:0]                byte_idx_q;
  logic [TCW-1:0]                wait_cnt_q;
  logic [7:0]                    csum_q;
  logic                          guard_q;
  logic [OUTPUT_DIM*ACT_BITS-1:0] buf_q;
  logic [7:0]                    frame_byte;
  logic                          last_run;
  logic                          is_payload;
  logic                          is_data;

  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;
  assign last_run   = (run_idx == runs_q - RUN_CNT_BITS'(1));
  // Payload covers run index and data bytes (checksum input); data excludes run index.
  assign is_payload = (byte_idx_q != '0) && (byte_idx_q != LAST_BYTE);
  assign is_data    = (byte_idx_q >= BIW'(2)) && (byte_idx_q != LAST_BYTE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Select the frame byte at byte_idx; data bytes come from the low end of the shifting buffer.
  always_comb begin
    frame_byte = buf_q[7:0];
    if (byte_idx_q == '0)             frame_byte = 8'hA5;
    else if (byte_idx_q == BIW'(1))   frame_byte = run_idx[7:0];
    else if (byte_idx_q == LAST_BYTE) frame_byte = csum_q;
  end

  // Next-state and handshake outputs; abort overrides everything outside IDLE.
  always_comb begin
    state_d      = state_q;
    eng_in_valid = 1'b0;
    tx_valid     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (num_runs != '0)) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        eng_in_valid = 1'b1;
        if (eng_in_ready) state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (eng_out_valid)              state_d = S_TX_ISSUE;
        else if (wait_cnt_q == TO_LAST) state_d = S_IDLE;
      end
      S_TX_ISSUE: begin
        if (!tx_busy) begin
          tx_valid = 1'b1;
          state_d  = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (!guard_q && !tx_busy)
          state_d = (byte_idx_q == LAST_BYTE) ? S_NEXT : S_TX_ISSUE;
      end
      S_NEXT: begin
        state_d = last_run ? S_IDLE : S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      eng_in_valid = 1'b0;
      tx_valid     = 1'b0;
    end
  end

  assign tx_data = tx_valid ? frame_byte : 8'h00;

  // Run bookkeeping, status flags, timeout counter, byte index and running checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runs_q     <= '0;
      run_idx    <= '0;
      done       <= 1'b0;
      err        <= ERR_NONE;
      byte_idx_q <= '0;
      wait_cnt_q <= '0;
      csum_q     <= '0;
      guard_q    <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == S_WAIT_RES) ? wait_cnt_q + TCW'(1) : '0;
      guard_q    <= tx_valid;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            runs_q  <= num_runs;
            run_idx <= '0;
            err     <= ERR_NONE;
            done    <= (num_runs == '0);
          end
        end
        S_WAIT_RES: begin
          if (!abort) begin
            if (eng_out_valid) begin
              byte_idx_q <= '0;
              csum_q     <= '0;
            end else if (wait_cnt_q == TO_LAST) begin
              err <= ERR_TIMEOUT;
            end
          end
        end
        S_TX_ISSUE: begin
          if (tx_valid && is_payload) csum_q <= csum_q ^ frame_byte;
        end
        S_TX_WAIT: begin
          if (!abort && !guard_q && !tx_busy) byte_idx_q <= byte_idx_q + BIW'(1);
        end
        S_NEXT: begin
          if (!abort) begin
            if (last_run) done <= 1'b1;
            else          run_idx <= run_idx + RUN_CNT_BITS'(1);
          end
        end
        default: ;
      endcase
      if (abort && (state_q != S_IDLE)) err <= ERR_ABORT;
    end
  end

  // Result buffer: loaded on a valid result in WAIT_RES, shifted one byte per data byte sent.
  always_ff @(posedge clk) begin
    if ((state_q == S_WAIT_RES) && eng_out_valid && !abort) buf_q <= eng_out_vec;
    else if (tx_valid && is_data)                           buf_q <= buf_q >> ACT_BITS;
  end

endmodule
